// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [1:0] WB_NOP   = 2'b00;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the reader in ID.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              load_use
);

  // $zero never carries a real dependency
  assign load_use = ex_mem_read && (ex_rt != REG_AW'(REG_ZERO)) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/freeze sequencer for the 5-stage pipeline.
// Optional HAZARD_PERF_EN adds saturating load-use/flush/freeze counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              mem_wb_bubble,
  output logic              mem_err,
  output logic [1:0]        state
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]       perf_lu_stalls,
  output logic [15:0]       perf_flushes,
  output logic [15:0]       perf_mem_frz
`endif
);

  state_e            state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              mem_err_q;
  logic              load_use;
  logic              freeze;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  // The illegal 2'b11 encoding lands in default and behaves as ERR
  always_comb begin
    freeze = 1'b1;
    case (state_q)
      ST_RUN:      freeze = mem_req && !mem_ready;
      ST_MEM_WAIT: freeze = !mem_ready;
      default:     freeze = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state_q    <= ST_MEM_WAIT;
            wait_cnt_q <= CNT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_q   <= ST_ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_ERR;
          mem_err_q <= 1'b1;
        end
      endcase
    end
  end

  // Branch beats load-use: the stalled ID instruction is squashed anyway
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign mem_err = mem_err_q;
  assign state   = state_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] perf_lu_q, perf_fl_q, perf_frz_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lu_q  <= '0;
      perf_fl_q  <= '0;
      perf_frz_q <= '0;
    end else begin
      perf_lu_q  <= sat_inc16(perf_lu_q, !freeze && !ex_branch_taken && load_use);
      perf_fl_q  <= sat_inc16(perf_fl_q, !freeze && ex_branch_taken);
      perf_frz_q <= sat_inc16(perf_frz_q, freeze);
    end
  end

  assign perf_lu_stalls = perf_lu_q;
  assign perf_flushes   = perf_fl_q;
  assign perf_mem_frz   = perf_frz_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write;
  logic          ex_mem_write, mem_wb_bubble, mem_err;
  logic [1:0]    state;
`ifdef HAZARD_PERF_EN
  logic [15:0]   perf_lu_stalls, perf_flushes, perf_mem_frz;
`endif

  pipe_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_err         (mem_err),
    .state           (state)
`ifdef HAZARD_PERF_EN
    ,
    .perf_lu_stalls  (perf_lu_stalls),
    .perf_flushes    (perf_flushes),
    .perf_mem_frz    (perf_mem_frz)
`endif
  );

  int cmps  = 0;
  int fails = 0;

  // Model: m_wait counts consecutive frozen cycles of the current access
  bit m_err  = 1'b0;
  int m_wait = 0;
  int m_lu   = 0;
  int m_fl   = 0;
  int m_fz   = 0;

  function automatic bit m_freeze();
    if (m_err) return 1'b1;
    if (m_wait > 0) return !mem_ready;
    return mem_req && !mem_ready;
  endfunction

  function automatic bit m_load_use();
    return ex_mem_read && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  function automatic logic [9:0] exp_vec();
    bit fz, br, lu;
    logic [1:0] st;
    fz = m_freeze();
    br = !fz && ex_branch_taken;
    lu = !fz && !ex_branch_taken && m_load_use();
    st = m_err ? 2'b10 : ((m_wait > 0) ? 2'b01 : 2'b00);
    return {!fz && !lu, !fz && !lu, br, br || lu, !fz, !fz, fz, m_err, st};
  endfunction

  function automatic logic [9:0] got_vec();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write,
            ex_mem_write, mem_wb_bubble, mem_err, state};
  endfunction

  task automatic drive(input bit rn, input int rs, input int rt, input bit urt,
                       input bit mr, input int ert, input bit br, input bit mq, input bit rdy);
    rst_n = rn; id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rt = urt;
    ex_mem_read = mr; ex_rt = AW'(ert); ex_branch_taken = br;
    mem_req = mq; mem_ready = rdy;
  endtask

  task automatic tick();
    bit fz, br, lu;
    fz = m_freeze();
    br = !fz && ex_branch_taken;
    lu = !fz && !ex_branch_taken && m_load_use();
    @(posedge clk);
    if (!rst_n) begin
      m_err = 1'b0; m_wait = 0; m_lu = 0; m_fl = 0; m_fz = 0;
    end else begin
      if (lu && m_lu < 65535) m_lu++;
      if (br && m_fl < 65535) m_fl++;
      if (fz && m_fz < 65535) m_fz++;
      if (!m_err) begin
        if (fz) begin
          m_wait++;
          if (m_wait == TMO) m_err = 1'b1;
        end else begin
          m_wait = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    if (got_vec() !== 10'b11_0011_0000) begin
      fails++; $display("FAIL reset got=%b exp=%b", got_vec(), 10'b11_0011_0000);
    end
    cmps++;
    tick();
  endtask

  task automatic test_load_use();
    // lw $2 in EX, add using $2 in ID: exactly one bubble
    drive(1, 2, 7, 1, 1, 2, 0, 0, 0);
    @(negedge clk);
    if (got_vec() !== exp_vec() || pc_write !== 1'b0 || id_ex_bubble !== 1'b1) begin
      fails++; $display("FAIL load_use_stall got=%b exp=%b", got_vec(), exp_vec());
    end
    cmps++;
    tick();
    drive(1, 2, 7, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    if (got_vec() !== 10'b11_0011_0000) begin
      fails++; $display("FAIL load_use_release got=%b exp=%b", got_vec(), 10'b11_0011_0000);
    end
    cmps++;
    tick();
  endtask

  task automatic test_no_stall();
    drive(1, 0, 3, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    if (got_vec() !== 10'b11_0011_0000) begin
      fails++; $display("FAIL no_stall_zero got=%b exp=%b", got_vec(), 10'b11_0011_0000);
    end
    cmps++;
    tick();
    drive(1, 1, 5, 0, 1, 5, 0, 0, 0);
    @(negedge clk);
    if (got_vec() !== 10'b11_0011_0000) begin
      fails++; $display("FAIL no_stall_rt_unused got=%b exp=%b", got_vec(), 10'b11_0011_0000);
    end
    cmps++;
    tick();
  endtask

  task automatic test_branch_priority();
    drive(1, 4, 0, 0, 1, 4, 1, 0, 0);
    @(negedge clk);
    if (got_vec() !== 10'b11_1111_0000) begin
      fails++; $display("FAIL branch_over_lu got=%b exp=%b", got_vec(), 10'b11_1111_0000);
    end
    cmps++;
    tick();
  endtask

  task automatic test_mem_freeze();
    for (int i = 0; i < 3; i++) begin
      drive(1, 2, 0, 0, 1, 2, i == 1, 1, 0);
      @(negedge clk);
      if (got_vec() !== exp_vec() || mem_wb_bubble !== 1'b1 || id_ex_bubble !== 1'b0) begin
        fails++; $display("FAIL mem_freeze_%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
      cmps++;
      tick();
    end
    if (state !== 2'b01) begin
      fails++; $display("FAIL mem_wait_state got=%b exp=01", state);
    end
    cmps++;
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    if (got_vec() !== 10'b11_0011_0001) begin
      fails++; $display("FAIL mem_ready_cycle got=%b exp=%b", got_vec(), 10'b11_0011_0001);
    end
    cmps++;
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    if (state !== 2'b00) begin
      fails++; $display("FAIL mem_back_to_run got=%b exp=00", state);
    end
    cmps++;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (got_vec() !== 10'b00_0000_1110 || got_vec() !== exp_vec()) begin
        fails++; $display("FAIL timeout_err_%0d got=%b exp=%b", i, got_vec(), 10'b00_0000_1110);
      end
      cmps++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    if (state !== 2'b00 || mem_err !== 1'b0) begin
      fails++; $display("FAIL timeout_reset got state=%b err=%b exp 00/0", state, mem_err);
    end
    cmps++;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    if (got_vec() !== 10'b11_0011_0000) begin
      fails++; $display("FAIL reset_mid_wait got=%b exp=%b", got_vec(), 10'b11_0011_0000);
    end
    cmps++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(24, 0) != 0,
            $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(1, 0),
            $urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(4, 0) == 0,
            $urandom_range(3, 0) == 0, $urandom_range(2, 0) != 0);
      @(negedge clk);
      if (got_vec() !== exp_vec()) begin
        fails++; $display("FAIL random_%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
      cmps++;
`ifdef HAZARD_PERF_EN
      if (perf_lu_stalls !== 16'(m_lu) || perf_flushes !== 16'(m_fl) || perf_mem_frz !== 16'(m_fz)) begin
        fails++; $display("FAIL random_perf_%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                          perf_lu_stalls, perf_flushes, perf_mem_frz, m_lu, m_fl, m_fz);
      end
      cmps++;
`endif
      tick();
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 3, 0, 0, 1, 3, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 6, 1, 1, 6, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); tick(); tick(); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    if (perf_lu_stalls !== 16'd2 || perf_flushes !== 16'd1 || perf_mem_frz !== 16'd3) begin
      fails++; $display("FAIL perf_counts got=%0d/%0d/%0d exp=2/1/3",
                        perf_lu_stalls, perf_flushes, perf_mem_frz);
    end
    cmps++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_priority();
    test_mem_freeze();
    test_timeout();
    test_reset_mid_wait();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
